multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multicycle RV32I core.
- Sits directly upstream of the instruction register. It generates IRWrite, which latches Instr and OldPC, and sequences PC, memory, ALU and register-file strobes for each instruction.
- Consumes op from the latched Instr and a memory ready handshake.
- Pure Moore FSM. Outputs decode from the state register, gated by mem_ready where stated.

Parameters:
- None. The opcode set is fixed: lw, sw, R-type, I-ALU, beq, jal, jalr.

Ports:
- clk  in  1  Rising-edge clock.
- reset  in  1  Asynchronous, active-high reset.
- op  in  7  Instr[6:0] from the instruction register.
- mem_ready  in  1  Memory has valid read data, or has accepted a write, this cycle.
- IRWrite  out  1  Latch RD into Instr and PC into OldPC.
- PCUpdate  out  1  Unconditional PC write.
- Branch  out  1  Conditional PC write. The datapath ANDs it with Zero.
- RegWrite  out  1  Register file write enable.
- MemWrite  out  1  Data memory write strobe.
- AdrSrc  out  1  Memory address select: 0 = PC, 1 = Result.
- ResultSrc  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = 4.
- ALUOp  out  2  ALU operation: 00 = add, 01 = sub, 10 = funct decode.
- instr_done  out  1  One-cycle pulse in the final state of each instruction.
- illegal_op  out  1  One-cycle pulse in DECODE when op is unsupported.

Behaviour:
- Reset:
  - State is forced to FETCH asynchronously.
  - While reset is high, every output is 0, including IRWrite, PCUpdate and instr_done.
  - On the first clock after release, the FSM is in FETCH.
- States and outputs. Any output not listed for a state is 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCUpdate = mem_ready.
  - Stays in FETCH while mem_ready=0. Goes to DECODE when mem_ready=1.
  - IRWrite and PCUpdate must never be high in a cycle where mem_ready=0.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00. This precomputes OldPC+Imm into ALUOut.
  - Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - 1100111 → JALR
    - any other value → FETCH, with illegal_op=1 for this cycle.
- MEMADR:
  - ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - Goes to MEMREAD if op=lw, otherwise MEMWRITE.
- MEMREAD:
  - AdrSrc=1, ResultSrc=00.
  - Holds while mem_ready=0. Goes to MEMWB when mem_ready=1.
- MEMWB:
  - ResultSrc=01, RegWrite=1, instr_done=1.
  - Goes to FETCH.
- MEMWRITE:
  - AdrSrc=1, ResultSrc=00, MemWrite=1.
  - Holds with MemWrite high until mem_ready=1.
  - On the mem_ready=1 cycle: instr_done=1, then goes to FETCH.
- EXECUTER:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - Goes to ALUWB.
- EXECUTEI:
  - ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - Goes to ALUWB.
- ALUWB:
  - ResultSrc=00, RegWrite=1, instr_done=1.
  - Goes to FETCH.
- BEQ:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1.
  - Goes to FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - PC takes OldPC+Imm; ALUOut takes OldPC+4.
  - Goes to ALUWB.
- JALR:
  - ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - Goes to JALRLINK.
- JALRLINK:
  - ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=10, RegWrite=1, instr_done=1.
  - Goes to FETCH.
- Latency, with mem_ready tied to 1:
  - lw 5 cycles; sw, R-type, I-ALU, jal and jalr 4 cycles; beq 3 cycles.
  - Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Boundary conditions:
  - op is sampled only in DECODE and MEMADR; changes in other states are ignored.
  - State encoding is full-case. Unreachable encodings go to FETCH.
  - Reset asserted mid-instruction aborts it immediately, with no partial RegWrite or MemWrite after the reset edge.
  - instr_done pulses exactly once per completed legal instruction. It never pulses for an illegal op.

Test Plan:
- Reset then release, mem_ready=1, op=0110011 → FETCH/DECODE/EXECUTER/ALUWB; IRWrite high in cycle 1 only; RegWrite and instr_done high in cycle 4 only.
- lw (op=0000011), mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD → 10 cycles total; IRWrite exactly once, in the cycle mem_ready rises; RegWrite with ResultSrc=01 in the final cycle.
- sw (op=0100011), mem_ready=0 for 2 MEMWRITE cycles → MemWrite high for 3 consecutive cycles with AdrSrc=1; RegWrite never high; instr_done on the third.
- beq (op=1100011) → 3 cycles; Branch=1 and ALUOp=01 in cycle 3; PCUpdate high only in FETCH.
- jal then jalr back-to-back → jal has PCUpdate in JAL and RegWrite in ALUWB; jalr has PCUpdate with ResultSrc=10 in JALR, then RegWrite with ALUSrcA=01 and ALUSrcB=10 in JALRLINK.
- op=1111111 → illegal_op pulse in DECODE, next state FETCH, no instr_done. Separately, reset asserted during MEMWRITE → MemWrite drops in the same cycle and the FSM is in FETCH after release.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback strobes; outputs decode from the state register.
//
// state      | meaning
// FETCH      | read instruction at PC, latch IR/OldPC and PC+4 on mem_ready
// DECODE     | register read, precompute OldPC+Imm, dispatch on op
// MEMADR     | compute load/store address RD1+Imm
// MEMREAD    | drive address from Result, wait for read data
// MEMWB      | write loaded data to the register file
// MEMWRITE   | hold store strobe until memory accepts it
// EXECUTER   | R-type ALU operation RD1 op RD2
// EXECUTEI   | I-type ALU operation RD1 op Imm
// ALUWB      | write ALUOut to the register file
// BEQ        | compare RD1-RD2, conditional PC write from ALUOut
// JAL        | PC <= OldPC+Imm, ALUOut <= OldPC+4
// JALR       | PC <= RD1+Imm
// JALRLINK   | write OldPC+4 to the register file
module multicycle_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTER,
    S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_JALR, S_JALRLINK
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  state_t state, next_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    IRWrite    = 1'b0;
    PCUpdate   = 1'b0;
    Branch     = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECUTER;
          OP_I:         next_state = S_EXECUTEI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          OP_JALR:      next_state = S_JALR;
          default: begin
            next_state = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b10;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        Branch     = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCUpdate   = 1'b1;
        next_state = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        PCUpdate   = 1'b1;
        next_state = S_JALRLINK;
      end
      S_JALRLINK: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
    // Reset is asynchronous, so the strobes must also drop combinationally
    // rather than waiting for the state register to settle in FETCH.
    if (reset) begin
      IRWrite    = 1'b0;
      PCUpdate   = 1'b0;
      Branch     = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-cycle expected output
// vectors go through a scoreboard queue and are compared as the DUT responds.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       mem_ready;
  logic       IRWrite, PCUpdate, Branch, RegWrite, MemWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       instr_done, illegal_op;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [6:0]  op;
    logic        mr;
    logic [15:0] exp;
  } stim_t;

  stim_t       stim[$];
  logic [15:0] sb[$];

  multicycle_ctrl_fsm dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // {IRWrite,PCUpdate,Branch,RegWrite,MemWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,instr_done,illegal_op}
  function automatic logic [15:0] ev(input logic irw, pcu, br, rw, mw, adr,
                                     input logic [1:0] rs, asa, asb, aop,
                                     input logic done, ill);
    return {irw, pcu, br, rw, mw, adr, rs, asa, asb, aop, done, ill};
  endfunction

  function automatic logic [15:0] e_fetch(input logic mr);
    return ev(mr, mr, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
  endfunction
  function automatic logic [15:0] e_decode(input logic ill);
    return ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, ill);
  endfunction
  function automatic logic [15:0] e_memwrite(input logic mr);
    return ev(0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, mr, 0);
  endfunction

  localparam logic [15:0] E_MEMADR   = 16'b000000_00_10_01_00_00;
  localparam logic [15:0] E_MEMREAD  = 16'b000001_00_00_00_00_00;
  localparam logic [15:0] E_MEMWB    = 16'b000100_01_00_00_00_10;
  localparam logic [15:0] E_EXECR    = 16'b000000_00_10_00_10_00;
  localparam logic [15:0] E_EXECI    = 16'b000000_00_10_01_10_00;
  localparam logic [15:0] E_ALUWB    = 16'b000100_00_00_00_00_10;
  localparam logic [15:0] E_BEQ      = 16'b001000_00_10_00_01_10;
  localparam logic [15:0] E_JAL      = 16'b010000_00_01_10_00_00;
  localparam logic [15:0] E_JALR     = 16'b010000_10_10_01_00_00;
  localparam logic [15:0] E_JALRLINK = 16'b000100_10_01_10_00_10;

  function automatic stim_t mk(input logic [6:0] o, input logic m, input logic [15:0] e);
    stim_t s;
    s.op = o; s.mr = m; s.exp = e;
    return s;
  endfunction

  function automatic logic [15:0] outs();
    return {IRWrite, PCUpdate, Branch, RegWrite, MemWrite, AdrSrc,
            ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal_op};
  endfunction

  // Drives one cycle's inputs on the falling edge, records the expectation,
  // and samples outputs 1 ns later, well clear of the rising edge.
  task automatic drive(input stim_t s, output logic [15:0] obs);
    @(negedge clk);
    op = s.op;
    mem_ready = s.mr;
    sb.push_back(s.exp);
    #1;
    obs = outs();
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    reset = 1'b1; op = OP_R; mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (outs() !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outs_mr1: got %h expected 0000", outs());
    end
    mem_ready = 1'b0; #1;
    checks++;
    if (outs() !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outs_mr0: got %h expected 0000", outs());
    end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1; #1;
    obs = outs();
    checks++;
    if (obs !== e_fetch(1'b1)) begin
      failures++;
      $display("FAIL reset_release_fetch: got %h expected %h", obs, e_fetch(1'b1));
    end
  endtask

  task automatic test_rtype();
    logic [15:0] obs, expv;
    stim = {};
    stim.push_back(mk(OP_R, 1, e_decode(0)));
    stim.push_back(mk(OP_R, 1, E_EXECR));
    stim.push_back(mk(OP_R, 1, E_ALUWB));
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], obs);
      expv = sb.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL rtype cyc%0d: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_itype();
    logic [15:0] obs, expv;
    stim = {};
    stim.push_back(mk(OP_I, 1, e_fetch(1)));
    stim.push_back(mk(OP_I, 1, e_decode(0)));
    stim.push_back(mk(OP_I, 1, E_EXECI));
    stim.push_back(mk(OP_I, 1, E_ALUWB));
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], obs);
      expv = sb.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL itype cyc%0d: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  // op is scrambled outside DECODE/MEMADR to show it is ignored there.
  task automatic test_lw_stalls();
    logic [15:0] obs, expv;
    stim = {};
    stim.push_back(mk(OP_BEQ, 0, e_fetch(0)));
    stim.push_back(mk(OP_R,   0, e_fetch(0)));
    stim.push_back(mk(OP_JAL, 1, e_fetch(1)));
    stim.push_back(mk(OP_LW,  1, e_decode(0)));
    stim.push_back(mk(OP_LW,  1, E_MEMADR));
    stim.push_back(mk(OP_SW,  0, E_MEMREAD));
    stim.push_back(mk(OP_BAD, 0, E_MEMREAD));
    stim.push_back(mk(OP_R,   0, E_MEMREAD));
    stim.push_back(mk(OP_SW,  1, E_MEMREAD));
    stim.push_back(mk(OP_BEQ, 1, E_MEMWB));
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], obs);
      expv = sb.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL lw cyc%0d: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_sw_stalls();
    logic [15:0] obs, expv;
    stim = {};
    stim.push_back(mk(OP_SW, 1, e_fetch(1)));
    stim.push_back(mk(OP_SW, 1, e_decode(0)));
    stim.push_back(mk(OP_SW, 1, E_MEMADR));
    stim.push_back(mk(OP_LW, 0, e_memwrite(0)));
    stim.push_back(mk(OP_LW, 0, e_memwrite(0)));
    stim.push_back(mk(OP_LW, 1, e_memwrite(1)));
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], obs);
      expv = sb.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL sw cyc%0d: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_beq();
    logic [15:0] obs, expv;
    stim = {};
    stim.push_back(mk(OP_BEQ, 1, e_fetch(1)));
    stim.push_back(mk(OP_BEQ, 1, e_decode(0)));
    stim.push_back(mk(OP_BEQ, 1, E_BEQ));
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], obs);
      expv = sb.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL beq cyc%0d: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] obs, expv;
    stim = {};
    stim.push_back(mk(OP_JAL,  1, e_fetch(1)));
    stim.push_back(mk(OP_JAL,  1, e_decode(0)));
    stim.push_back(mk(OP_JAL,  1, E_JAL));
    stim.push_back(mk(OP_JAL,  1, E_ALUWB));
    stim.push_back(mk(OP_JALR, 1, e_fetch(1)));
    stim.push_back(mk(OP_JALR, 1, e_decode(0)));
    stim.push_back(mk(OP_JALR, 1, E_JALR));
    stim.push_back(mk(OP_JALR, 1, E_JALRLINK));
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], obs);
      expv = sb.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL jal_jalr cyc%0d: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_illegal();
    logic [15:0] obs, expv;
    stim = {};
    stim.push_back(mk(OP_BAD, 1, e_fetch(1)));
    stim.push_back(mk(OP_BAD, 1, e_decode(1)));
    stim.push_back(mk(OP_BAD, 0, e_fetch(0)));
    stim.push_back(mk(OP_BAD, 1, e_fetch(1)));
    stim.push_back(mk(OP_R,   1, e_decode(0)));
    stim.push_back(mk(OP_R,   1, E_EXECR));
    stim.push_back(mk(OP_R,   1, E_ALUWB));
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], obs);
      expv = sb.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL illegal cyc%0d: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    logic [15:0] obs, expv;
    stim = {};
    stim.push_back(mk(OP_SW, 1, e_fetch(1)));
    stim.push_back(mk(OP_SW, 1, e_decode(0)));
    stim.push_back(mk(OP_SW, 1, E_MEMADR));
    stim.push_back(mk(OP_SW, 0, e_memwrite(0)));
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], obs);
      expv = sb.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL rst_store cyc%0d: got %h expected %h", i, obs, expv);
      end
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 16'h0000) begin
      failures++;
      $display("FAIL rst_store_abort: got %h expected 0000", outs());
    end
    mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (outs() !== 16'h0000) begin
      failures++;
      $display("FAIL rst_store_held: got %h expected 0000", outs());
    end
    @(negedge clk);
    reset = 1'b0; op = OP_SW; #1;
    checks++;
    if (outs() !== e_fetch(1'b1)) begin
      failures++;
      $display("FAIL rst_store_release: got %h expected %h", outs(), e_fetch(1'b1));
    end
    stim = {};
    stim.push_back(mk(OP_BEQ, 1, e_decode(0)));
    stim.push_back(mk(OP_BEQ, 1, E_BEQ));
    stim.push_back(mk(OP_BEQ, 1, e_fetch(1)));
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], obs);
      expv = sb.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL rst_store_after cyc%0d: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_lw_stalls();
    test_sw_stalls();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_reset_mid_store();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
